// File: rtl/bus_arbiter_rr_if.sv
// Signal bundle between the cache-side requesters, the round-robin arbiter and the memory bus.
// The slave modport is the arbiter's view; master is the surrounding requester/memory view.
interface bus_arbiter_rr_if #(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned BUS_DATA_WIDTH  = 64,
    parameter int unsigned BUS_TAG_WIDTH   = 13,
    parameter int unsigned MAX_OUTSTANDING = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_PORTS-1:0]                port_reqcyc;
    logic [NUM_PORTS*BUS_DATA_WIDTH-1:0] port_req;
    logic [NUM_PORTS*BUS_TAG_WIDTH-1:0]  port_reqtag;
    logic [NUM_PORTS-1:0]                port_reqack;
    logic                                bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]           bus_req;
    logic [BUS_TAG_WIDTH-1:0]            bus_reqtag;
    logic                                bus_reqack;
    logic                                bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0]           bus_resp;
    logic [BUS_TAG_WIDTH-1:0]            bus_resptag;
    logic                                bus_respack;
    logic [NUM_PORTS-1:0]                port_respcyc;
    logic [BUS_DATA_WIDTH-1:0]           port_resp;
    logic [BUS_TAG_WIDTH-1:0]            port_resptag;
    logic [NUM_PORTS-1:0]                port_respack;
    logic [CNT_W-1:0]                    outstanding;
    logic                                resp_err;

    modport slave (
        input  port_reqcyc, port_req, port_reqtag, port_respack,
               bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output port_reqack, bus_reqcyc, bus_req, bus_reqtag, bus_respack,
               port_respcyc, port_resp, port_resptag, outstanding, resp_err
    );

    modport master (
        output port_reqcyc, port_req, port_reqtag, port_respack,
               bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  port_reqack, bus_reqcyc, bus_req, bus_reqtag, bus_respack,
               port_respcyc, port_resp, port_resptag, outstanding, resp_err
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// N-port round-robin memory-bus arbiter with an in-order owner FIFO used to route
// response bursts back to the requester that issued the matching request.
module bus_arbiter_rr #(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned BUS_DATA_WIDTH  = 64,
    parameter int unsigned BUS_TAG_WIDTH   = 13,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic             clk,
    input logic             reset,
    bus_arbiter_rr_if.slave bif
);
    localparam int unsigned GNT_W = $clog2(NUM_PORTS);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [GNT_W-1:0] gnt, gnt_nxt;
    logic [GNT_W-1:0] rr_ptr, rr_ptr_nxt;
    logic             first_ack, first_ack_nxt;
    logic             push, pop;

    logic [GNT_W-1:0] owner_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty, fifo_full;
    logic [GNT_W-1:0] head;

    logic             respcyc_q, resp_owned_q, resp_err_q;
    logic             gnt_reqcyc;
    logic             win_found;
    logic [GNT_W-1:0] win_idx;
    int unsigned      cand;

    logic [BUS_DATA_WIDTH-1:0] req_arr [NUM_PORTS];
    logic [BUS_TAG_WIDTH-1:0]  tag_arr [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign req_arr[i] = bif.port_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        assign tag_arr[i] = bif.port_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign head       = owner_mem[rd_ptr];
    assign gnt_reqcyc = bif.port_reqcyc[gnt];

    // First requesting port at or above rr_ptr, wrapping around the port count
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!win_found && bif.port_reqcyc[GNT_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = GNT_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            first_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            first_ack <= first_ack_nxt;
        end
    end

    // Only the first accepted beat of a transaction claims an owner slot
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        rr_ptr_nxt    = rr_ptr;
        first_ack_nxt = first_ack;
        push          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_found && !fifo_full) begin
                    gnt_nxt       = win_idx;
                    first_ack_nxt = 1'b0;
                    state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!gnt_reqcyc) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = (gnt == GNT_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
                end else if (bif.bus_reqack && !first_ack) begin
                    push          = 1'b1;
                    first_ack_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bif.bus_reqcyc  = 1'b0;
        bif.bus_req     = '0;
        bif.bus_reqtag  = '0;
        bif.port_reqack = '0;
        if (state == ST_GRANT && gnt_reqcyc) begin
            bif.bus_reqcyc       = 1'b1;
            bif.bus_req          = req_arr[gnt];
            bif.bus_reqtag       = tag_arr[gnt];
            bif.port_reqack[gnt] = bif.bus_reqack;
        end
    end

    // Orphan beats are acked so memory never stalls on a response nobody owns
    always_comb begin
        bif.port_respcyc = '0;
        bif.bus_respack  = bif.bus_respcyc;
        if (!fifo_empty) begin
            bif.port_respcyc[head] = bif.bus_respcyc;
            bif.bus_respack        = bif.port_respack[head];
        end
    end

    assign bif.port_resp    = bif.bus_resp;
    assign bif.port_resptag = bif.bus_resptag;

    assign pop = respcyc_q && !bif.bus_respcyc && resp_owned_q && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) owner_mem[wr_ptr] <= gnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // End-of-burst detect; a burst that finished while unowned must not pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            respcyc_q    <= 1'b0;
            resp_owned_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            respcyc_q    <= bif.bus_respcyc;
            resp_owned_q <= bif.bus_respcyc && !fifo_empty;
            resp_err_q   <= resp_err_q || (bif.bus_respcyc && fifo_empty);
        end
    end

    assign bif.outstanding = count;
    assign bif.resp_err    = resp_err_q;
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised N-port round-robin arbiter between the cache-side requesters (I$, D$, and later prefetch/PTW ports) and the single memory bus. It grants one requester at a time for a whole request transaction and records the owner of every accepted request in an in-order owner FIFO. It routes each bus response back to that owner and merges response acks onto the bus. It replaces the fixed two-port I$/D$ arbiter and adds fairness, response routing, outstanding-request tracking and a protocol-error flag.

## Interface
- NUM_PORTS, 4, number of requesters; 2..8
- BUS_DATA_WIDTH, 64, bus data width
- BUS_TAG_WIDTH, 13, bus tag width
- MAX_OUTSTANDING, 4, owner FIFO depth; power of 2, at least 2
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- port_reqcyc  input  NUM_PORTS  per-port request valid; bit i = port i
- port_req  input  NUM_PORTS*BUS_DATA_WIDTH  per-port request data; slice i = port i
- port_reqtag  input  NUM_PORTS*BUS_TAG_WIDTH  per-port request tag
- port_reqack  output  NUM_PORTS  bus_reqack routed to the granted port only
- bus_reqcyc  output  1  request valid to memory
- bus_req  output  BUS_DATA_WIDTH  muxed request data
- bus_reqtag  output  BUS_TAG_WIDTH  muxed request tag
- bus_reqack  input  1  memory accepts the current request beat
- bus_respcyc  input  1  response beat valid from memory
- bus_resp  input  BUS_DATA_WIDTH  response data
- bus_resptag  input  BUS_TAG_WIDTH  response tag
- bus_respack  output  1  response-beat ack to memory
- port_respcyc  output  NUM_PORTS  bus_respcyc routed to the owner port
- port_resp  output  BUS_DATA_WIDTH  bus_resp broadcast to all ports
- port_resptag  output  BUS_TAG_WIDTH  bus_resptag broadcast to all ports
- port_respack  input  NUM_PORTS  per-port response ack
- outstanding  output  $clog2(MAX_OUTSTANDING)+1  owner FIFO occupancy
- resp_err  output  1  sticky flag: a response arrived with no owner

## Operation
- The arbiter has two states, IDLE and GRANT, plus a registered grant index `gnt` and a round-robin pointer `rr_ptr`.
- IDLE, arbitration:
  - Arbitration runs only if some port_reqcyc bit is set and outstanding < MAX_OUTSTANDING.
  - The winner is the first requesting port found searching from rr_ptr upward, wrapping modulo NUM_PORTS.
  - On a win: gnt is loaded with the winner, the first-ack flag is cleared, and the state goes to GRANT.
- GRANT, request phase:
  - bus_reqcyc/bus_req/bus_reqtag follow the gnt slice combinationally.
  - port_reqack[gnt] = bus_reqack; all other port_reqack bits are 0.
  - On the first bus_reqack of the transaction, gnt is pushed into the owner FIFO and the first-ack flag is set. Later beats do not push.
  - When port_reqcyc[gnt] is 0: the bus outputs are 0, the state returns to IDLE, and rr_ptr becomes (gnt+1) mod NUM_PORTS.
  - A transaction that drops reqcyc with no ack pushes nothing.
- IDLE outputs: bus_reqcyc, bus_req, bus_reqtag are 0 and port_reqack is all 0.
- Response routing, when the FIFO is non-empty:
  - port_respcyc[head] = bus_respcyc; all other bits are 0.
  - bus_respack = port_respack[head].
- End of response: a registered copy of bus_respcyc detects the 1->0 edge. That edge pops the head; the pop takes effect at the posedge after the first idle cycle.
- Push and pop in the same cycle leave occupancy unchanged. Read and write pointers wrap modulo MAX_OUTSTANDING.
- Orphan response (bus_respcyc=1 while the FIFO is empty):
  - bus_respack = 1 so memory does not hang; port_respcyc stays 0.
  - resp_err is set and stays set until reset.
  - No pop occurs on the subsequent 1->0 edge.
- Every accepted request is assumed to produce exactly one response burst, and memory returns bursts in acceptance order.

## Timing
- Reset value (while reset=0, asynchronous): state IDLE, gnt=0, rr_ptr=0, FIFO empty, outstanding=0, resp_err=0.
- With those registers, every output is 0, except that pass-through outputs follow their inputs per the rules above.
- A reset mid-transaction drops the grant and all outstanding ownership immediately.
- Grant latency: a request raised in cycle t while IDLE gives bus_reqcyc=1 in cycle t+1.
- Back-to-back: after release, the state is IDLE for one cycle; the next grant drives the bus two cycles after the previous port's reqcyc fell.
- Full FIFO: no grant is issued until a pop. A pop in cycle t allows arbitration in cycle t+1.
- Occupancy: outstanding increments at the posedge ending the first-ack cycle and decrements at the posedge ending the first cycle with bus_respcyc=0.
- Simultaneous requests: resolved purely by rr_ptr. A port's reqcyc held continuously keeps the grant indefinitely (no preemption).

## Test plan
- Reset, then port 2 raises reqcyc with req=64'h1000 and tag=5; ack in cycle 2 -> cycle 1: bus_req=64'h1000, bus_reqtag=5, only port_reqack[2] pulses; outstanding=1.
- Response for that request: 8-beat burst with respack from port 2 -> port_respcyc=4'b0100 for 8 cycles, bus_respack follows port 2, outstanding=0 one cycle after the burst.
- All 4 ports request continuously, each transaction acked and released once -> grant order 0,1,2,3,0.
- Issue 4 acked requests with no responses -> outstanding=4 and a 5th request is not granted. One full response burst -> the grant occurs the cycle after the pop.
- bus_respcyc=1 with the FIFO empty -> bus_respack=1, port_respcyc=0, resp_err=1 and it stays 1.
- Assert reset low mid-burst with outstanding=3 -> all outputs 0 and outstanding=0 asynchronously; rr_ptr=0 after release.
